// File: rtl/mult_acc_stage.sv
// Frame accumulator behind the 16x16 multiplier: sums products until in_last, then
// presents sum/count/overflow through a registered valid/ready output. Optional MULT_ACC_SAT_EN.
module mult_acc_stage #(
    parameter int PROD_W = 32,
    parameter int ACC_W  = 40,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_product,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic [LEN_W-1:0]  out_count,
    output logic              out_ovf
);

    logic [ACC_W-1:0] acc_reg;
    logic [LEN_W-1:0] cnt_reg;
    logic             ovf_reg;
    logic             first_reg;

    logic             out_valid_reg;
    logic [ACC_W-1:0] out_sum_reg;
    logic [LEN_W-1:0] out_count_reg;
    logic             out_ovf_reg;

    logic             accept;
    logic [ACC_W:0]   sum_wide;
    logic [ACC_W-1:0] acc_next;
    logic             nov;
    logic [LEN_W-1:0] cnt_next;

    // A held result blocks every beat, last or not, until it drains.
    assign in_ready = !out_valid_reg || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        sum_wide = {1'b0, acc_reg} + (ACC_W+1)'(in_product);
        acc_next = sum_wide[ACC_W-1:0];
        nov      = 1'b0;
        if (first_reg) begin
            acc_next = ACC_W'(in_product);
        end else begin
            nov = sum_wide[ACC_W];
`ifdef MULT_ACC_SAT_EN
            // Once pinned at all-ones, further adds keep carrying, so the value sticks.
            if (sum_wide[ACC_W]) begin
                acc_next = '1;
            end
`endif
        end
        cnt_next = (cnt_reg == {LEN_W{1'b1}}) ? cnt_reg : cnt_reg + LEN_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_reg       <= '0;
            cnt_reg       <= '0;
            ovf_reg       <= 1'b0;
            first_reg     <= 1'b1;
            out_valid_reg <= 1'b0;
            out_sum_reg   <= '0;
            out_count_reg <= '0;
            out_ovf_reg   <= 1'b0;
        end else begin
            if (accept && in_last) begin
                out_sum_reg   <= acc_next;
                out_count_reg <= cnt_next;
                out_ovf_reg   <= ovf_reg | nov;
                out_valid_reg <= 1'b1;
                acc_reg       <= '0;
                cnt_reg       <= '0;
                ovf_reg       <= 1'b0;
                first_reg     <= 1'b1;
            end else begin
                if (accept) begin
                    acc_reg   <= acc_next;
                    cnt_reg   <= cnt_next;
                    ovf_reg   <= ovf_reg | nov;
                    first_reg <= 1'b0;
                end
                if (out_valid_reg && out_ready) begin
                    out_valid_reg <= 1'b0;
                end
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign out_sum   = out_sum_reg;
    assign out_count = out_count_reg;
    assign out_ovf   = out_ovf_reg;

endmodule

// File: tb/tb_mult_acc_stage.sv
// Scoreboard bench for mult_acc_stage (ACC_W=33, LEN_W=2 to reach overflow and count saturation).
module tb_mult_acc_stage;

    localparam int PROD_W = 32;
    localparam int ACC_W  = 33;
    localparam int LEN_W  = 2;

    typedef struct packed {
        logic [ACC_W-1:0] sum;
        logic [LEN_W-1:0] cnt;
        logic             ovf;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [PROD_W-1:0] in_product;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_sum;
    logic [LEN_W-1:0]  out_count;
    logic              out_ovf;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    mult_acc_stage #(.PROD_W(PROD_W), .ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_product(in_product), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_count(out_count), .out_ovf(out_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    task automatic push_exp(input logic [ACC_W-1:0] s, input logic [LEN_W-1:0] c, input logic o);
        exp_t e;
        e.sum = s;
        e.cnt = c;
        e.ovf = o;
        exp_q.push_back(e);
    endtask

    // Called at posedge+1; returns at posedge+1 of the accepting edge, in_valid left high.
    task automatic send_beat(input logic [PROD_W-1:0] p, input logic last);
        int waited;
        in_valid   = 1'b1;
        in_product = p;
        in_last    = last;
        waited     = 0;
        @(negedge clk);
        while (!in_ready && waited < 200) begin
            waited++;
            @(negedge clk);
        end
        if (!in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL beat_accept_timeout: in_ready=%0b, expected 1", in_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Monitor: a transfer happens at the next posedge whenever valid && ready here.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_result: sum=0x%0h count=%0d, expected no result", out_sum, out_count);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("mon_sum", 64'(out_sum), 64'(e.sum));
                chk("mon_count", 64'(out_count), 64'(e.cnt));
                chk("mon_ovf", 64'(out_ovf), 64'(e.ovf));
            end
        end
    end

    initial begin
        int waited;
        rst_n = 1'b0; in_valid = 1'b0; in_product = '0; in_last = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_sum", 64'(out_sum), 64'd0);
        chk("rst_out_count", 64'(out_count), 64'd0);
        chk("rst_out_ovf", 64'(out_ovf), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Reset mid-frame discards the partial sum
        send_beat(32'd5, 1'b0);
        send_beat(32'd7, 1'b0);
        idle();
        rst_n = 1'b0;
        #2;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        push_exp(33'd9, 2'd1, 1'b0);
        send_beat(32'd9, 1'b1);
        idle();
        @(posedge clk); #1;

        // Frame 3,4,5 then next frame with no bubble
        push_exp(33'd12, 2'd3, 1'b0);
        send_beat(32'd3, 1'b0);
        send_beat(32'd4, 1'b0);
        send_beat(32'd5, 1'b1);
        chk("f345_out_valid", 64'(out_valid), 64'd1);
        chk("f345_in_ready", 64'(in_ready), 64'd1);
        send_beat(32'd1, 1'b0);
        chk("f345_one_cycle", 64'(out_valid), 64'd0);
        push_exp(33'd3, 2'd2, 1'b0);
        send_beat(32'd2, 1'b1);
        idle();
        @(posedge clk); #1;

        // Backpressure on a single-beat frame
        out_ready = 1'b0;
        push_exp(33'h0FFFE0001, 2'd1, 1'b0);
        send_beat(32'hFFFE0001, 1'b1);
        in_product = 32'h11;
        in_last    = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_out_valid", 64'(out_valid), 64'd1);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            chk("bp_out_sum", 64'(out_sum), 64'h0FFFE0001);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        push_exp(33'h33, 2'd2, 1'b0);
        send_beat(32'h22, 1'b1);
        idle();
        @(posedge clk); #1;

        // Overflow: three beats of all-ones in a 33-bit accumulator
`ifdef MULT_ACC_SAT_EN
        push_exp(33'h1FFFFFFFF, 2'd3, 1'b1);
`else
        push_exp(33'h0FFFFFFFD, 2'd3, 1'b1);
`endif
        send_beat(32'hFFFFFFFF, 1'b0);
        send_beat(32'hFFFFFFFF, 1'b0);
        send_beat(32'hFFFFFFFF, 1'b1);
        idle();
        @(posedge clk); #1;

        // Counter saturation: five beats of 1 with a 2-bit counter
        push_exp(33'd5, 2'd3, 1'b0);
        for (int i = 0; i < 5; i++) send_beat(32'd1, (i == 4));
        idle();
        @(posedge clk); #1;

        // Back-to-back single-beat frames
        push_exp(33'd10, 2'd1, 1'b0);
        push_exp(33'd20, 2'd1, 1'b0);
        push_exp(33'd30, 2'd1, 1'b0);
        send_beat(32'd10, 1'b1);
        chk("b2b_valid_1", 64'(out_valid), 64'd1);
        send_beat(32'd20, 1'b1);
        chk("b2b_valid_2", 64'(out_valid), 64'd1);
        send_beat(32'd30, 1'b1);
        chk("b2b_valid_3", 64'(out_valid), 64'd1);
        idle();
        @(posedge clk); #1;
        chk("b2b_drained", 64'(out_valid), 64'd0);
        chk("drain_keeps_sum", 64'(out_sum), 64'd30);
        chk("drain_keeps_count", 64'(out_count), 64'd1);

        waited = 0;
        while (exp_q.size() != 0 && waited < 50) begin
            waited++;
            @(posedge clk);
        end
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
